// File: rtl/sha256_pkg.sv
// Shared SHA-256 sequencing constants, the controller state encoding and the
// initial hash value used by both the controller and the compression datapath.
package sha256_pkg;

   localparam int NUM_ROUNDS = 64;
   localparam int MSG_WORDS  = 16;
   localparam int IDX_W      = 7;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_e;

   // H0..H7, index 0 first
   localparam logic [0:7][31:0] IV = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// Block-start handshake plus the datapath enables and round index driven by
// the SHA-256 round controller.
interface sha256_round_ctrl_if;
   import sha256_pkg::*;

   logic             start;
   logic             first_blk;
   logic             ready;
   logic             busy;
   logic [IDX_W-1:0] round_idx;
   logic             iv_load;
   logic             wv_load;
   logic             round_en;
   logic             w_from_msg;
   logic             sched_en;
   logic             hash_upd;
   logic             done;

   modport master (
      output start, first_blk,
      input  ready, busy, round_idx, iv_load, wv_load, round_en,
             w_from_msg, sched_en, hash_upd, done
   );

   modport slave (
      input  start, first_blk,
      output ready, busy, round_idx, iv_load, wv_load, round_en,
             w_from_msg, sched_en, hash_upd, done
   );

endinterface

// File: rtl/sha256_round_ctrl.sv
// Round sequencer for one SHA-256 compression: IDLE -> INIT -> 64 x ROUND ->
// FINAL -> DONE. All outputs are decoded from state and round counter only.
//
//   state | meaning
//   IDLE  | ready for a block; start accepted here only
//   INIT  | load working variables from H (and H from IV on a first block)
//   ROUND | one compression round per cycle, round_idx 0..63
//   FINAL | fold working variables back into H
//   DONE  | digest in H valid for this cycle
module sha256_round_ctrl
   import sha256_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   sha256_round_ctrl_if.slave  bus
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic             fb_q,    fb_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         fb_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         fb_q    <= fb_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = '0;
      fb_d    = fb_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               fb_d    = bus.first_blk;
               state_d = INIT;
            end
         end
         INIT:  state_d = ROUND;
         ROUND: begin
            // Counter returns to 0 on exit, so it never passes the last round.
            if (idx_q == IDX_W'(NUM_ROUNDS - 1)) begin
               state_d = FINAL;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         FINAL:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.ready      = 1'b0;
      bus.busy       = 1'b1;
      bus.round_idx  = '0;
      bus.iv_load    = 1'b0;
      bus.wv_load    = 1'b0;
      bus.round_en   = 1'b0;
      bus.w_from_msg = 1'b0;
      bus.sched_en   = 1'b0;
      bus.hash_upd   = 1'b0;
      bus.done       = 1'b0;
      case (state_q)
         IDLE: begin
            bus.ready = 1'b1;
            bus.busy  = 1'b0;
         end
         INIT: begin
            bus.wv_load = 1'b1;
            bus.iv_load = fb_q;
         end
         ROUND: begin
            bus.round_idx  = idx_q;
            bus.round_en   = 1'b1;
            bus.sched_en   = 1'b1;
            bus.w_from_msg = (idx_q < IDX_W'(MSG_WORDS));
         end
         FINAL: bus.hash_upd = 1'b1;
         DONE:  bus.done     = 1'b1;
         default: begin
            bus.ready = 1'b1;
            bus.busy  = 1'b0;
         end
      endcase
   end

endmodule
